// File: rtl/pmp_check_arbiter_pkg.sv
// Shared types for the IO-PMP check arbiter: FSM states, channel owner and
// AXI burst encodings.
package pmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHK_FIRST,
    CHK_LAST,
    RESP
  } pmp_arb_state_e;

  typedef enum logic {
    OWNER_AR = 1'b0,
    OWNER_AW = 1'b1
  } pmp_arb_owner_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic riscv::pmp_access_t ownerAccess(input pmp_arb_owner_e owner);
    return (owner == OWNER_AW) ? riscv::ACCESS_WRITE : riscv::ACCESS_READ;
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Subset of the shared riscv package: privilege level and PMP access type.
package riscv;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } pmp_access_t;

endpackage

// File: rtl/pmp_check_arbiter_last_addr.sv
// Combinational last-byte address of an AXI burst. err_o flags a reserved
// burst type or a burst that runs past the top of the address space.
module axi_burst_last_addr
  import pmp_arb_pkg::*;
#(
  parameter int unsigned PLEN      = 56,
  parameter int unsigned AXI_LEN_W = 8
) (
  input  logic [PLEN-1:0]      addr_i,
  input  logic [AXI_LEN_W-1:0] len_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [PLEN-1:0]      last_o,
  output logic                 err_o
);

  localparam int unsigned W = PLEN + 1;

  logic [W-1:0] addrExt;
  logic [W-1:0] beatMask;
  logic [W-1:0] totalBytes;
  logic [W-1:0] lastExt;
  logic         reservedBurst;

  // One spare top bit catches the carry out of the address space.
  always_comb begin
    addrExt       = {1'b0, addr_i};
    beatMask      = (W'(1) << size_i) - W'(1);
    totalBytes    = (W'(len_i) + W'(1)) << size_i;
    lastExt       = addrExt;
    reservedBurst = 1'b0;
    case (burst_i)
      BURST_FIXED: lastExt = addrExt | beatMask;
      BURST_INCR:  lastExt = (addrExt & ~beatMask) + totalBytes - W'(1);
      BURST_WRAP:  lastExt = (addrExt & ~(totalBytes - W'(1))) + totalBytes - W'(1);
      default:     reservedBurst = 1'b1;
    endcase
    err_o  = reservedBurst | lastExt[PLEN];
    last_o = lastExt[PLEN-1:0];
  end

endmodule

// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP between the AXI AR and AW requesters: checks the
// first and last byte of each granted burst and returns one verdict per request.
module pmp_check_arbiter
  import pmp_arb_pkg::*;
#(
  parameter int unsigned PLEN        = 56,
  parameter int unsigned AXI_LEN_W   = 8,
  parameter bit          RR_RESET_AR = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  riscv::priv_lvl_t     priv_lvl_i,

  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [PLEN-1:0]      ar_addr_i,
  input  logic [AXI_LEN_W-1:0] ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  output logic                 ar_rsp_valid_o,
  input  logic                 ar_rsp_ready_i,
  output logic                 ar_rsp_allow_o,

  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [PLEN-1:0]      aw_addr_i,
  input  logic [AXI_LEN_W-1:0] aw_len_i,
  input  logic [2:0]           aw_size_i,
  input  logic [1:0]           aw_burst_i,
  output logic                 aw_rsp_valid_o,
  input  logic                 aw_rsp_ready_i,
  output logic                 aw_rsp_allow_o,

  output logic [PLEN-1:0]      pmp_addr_o,
  output riscv::pmp_access_t   pmp_access_type_o,
  input  logic                 pmp_allow_i
);

  pmp_arb_state_e state_q, state_d;
  pmp_arb_owner_e owner_q, owner_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic [PLEN-1:0] lastAddr_q, lastAddr_d;
  logic            err_q, err_d;
  logic            allow_q, allow_d;
  logic            rrAr_q, rrAr_d;

  logic                 grantAr, grantAw;
  logic [PLEN-1:0]      selAddr, calcLast;
  logic [AXI_LEN_W-1:0] selLen;
  logic [2:0]           selSize;
  logic [1:0]           selBurst;
  logic                 calcErr;

  // Privilege goes straight to the external PMP; it is not needed here.
  logic unusedPriv;
  assign unusedPriv = ^priv_lvl_i;

  assign grantAr    = (state_q == IDLE) && ar_valid_i && (!aw_valid_i || rrAr_q);
  assign grantAw    = (state_q == IDLE) && aw_valid_i && !grantAr;
  assign ar_ready_o = grantAr;
  assign aw_ready_o = grantAw;

  assign selAddr  = grantAw ? aw_addr_i  : ar_addr_i;
  assign selLen   = grantAw ? aw_len_i   : ar_len_i;
  assign selSize  = grantAw ? aw_size_i  : ar_size_i;
  assign selBurst = grantAw ? aw_burst_i : ar_burst_i;

  axi_burst_last_addr #(
    .PLEN      (PLEN),
    .AXI_LEN_W (AXI_LEN_W)
  ) u_lastAddr (
    .addr_i  (selAddr),
    .len_i   (selLen),
    .size_i  (selSize),
    .burst_i (selBurst),
    .last_o  (calcLast),
    .err_o   (calcErr)
  );

  // The round-robin pointer only moves when both channels competed.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    lastAddr_d = lastAddr_q;
    err_d      = err_q;
    allow_d    = allow_q;
    rrAr_d     = rrAr_q;
    case (state_q)
      IDLE: begin
        if (grantAr || grantAw) begin
          owner_d    = grantAw ? OWNER_AW : OWNER_AR;
          addr_d     = selAddr;
          lastAddr_d = calcLast;
          err_d      = calcErr;
          if (ar_valid_i && aw_valid_i) rrAr_d = grantAw;
          state_d    = CHK_FIRST;
        end
      end
      CHK_FIRST: begin
        allow_d = pmp_allow_i;
        state_d = CHK_LAST;
      end
      CHK_LAST: begin
        allow_d = allow_q & pmp_allow_i & ~err_q;
        state_d = RESP;
      end
      RESP: begin
        if ((owner_q == OWNER_AR && ar_rsp_ready_i) ||
            (owner_q == OWNER_AW && aw_rsp_ready_i)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    pmp_addr_o        = '0;
    pmp_access_type_o = riscv::ACCESS_NONE;
    ar_rsp_valid_o    = 1'b0;
    aw_rsp_valid_o    = 1'b0;
    ar_rsp_allow_o    = 1'b0;
    aw_rsp_allow_o    = 1'b0;
    case (state_q)
      CHK_FIRST: begin
        pmp_addr_o        = addr_q;
        pmp_access_type_o = ownerAccess(owner_q);
      end
      CHK_LAST: begin
        pmp_addr_o        = lastAddr_q;
        pmp_access_type_o = ownerAccess(owner_q);
      end
      RESP: begin
        ar_rsp_valid_o = (owner_q == OWNER_AR);
        aw_rsp_valid_o = (owner_q == OWNER_AW);
        ar_rsp_allow_o = (owner_q == OWNER_AR) && allow_q;
        aw_rsp_allow_o = (owner_q == OWNER_AW) && allow_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_AR;
      addr_q     <= '0;
      lastAddr_q <= '0;
      err_q      <= 1'b0;
      allow_q    <= 1'b0;
      rrAr_q     <= RR_RESET_AR;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      lastAddr_q <= lastAddr_d;
      err_q      <= err_d;
      allow_q    <= allow_d;
      rrAr_q     <= rrAr_d;
    end
  end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Bench for pmp_check_arbiter: directed scenarios plus randomized bursts checked
// against an arithmetic burst model and an address-range PMP model.
module tb_pmp_check_arbiter;
  import riscv::*;

  logic              clk = 1'b0;
  logic              rst;
  priv_lvl_t         priv;
  logic              arValid, arReady, arRspValid, arRspReady, arRspAllow;
  logic [55:0]       arAddr;
  logic [7:0]        arLen;
  logic [2:0]        arSize;
  logic [1:0]        arBurst;
  logic              awValid, awReady, awRspValid, awRspReady, awRspAllow;
  logic [55:0]       awAddr;
  logic [7:0]        awLen;
  logic [2:0]        awSize;
  logic [1:0]        awBurst;
  logic [55:0]       pmpAddr;
  pmp_access_t       pmpAccess;
  logic              pmpAllow;
  logic [55:0]       denyLo, denyHi;
  int                checkCount = 0;
  int                passCount = 0;
  int                failCount = 0;

  pmp_check_arbiter #(.PLEN(56), .AXI_LEN_W(8), .RR_RESET_AR(1'b1)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .priv_lvl_i        (priv),
    .ar_valid_i        (arValid),
    .ar_ready_o        (arReady),
    .ar_addr_i         (arAddr),
    .ar_len_i          (arLen),
    .ar_size_i         (arSize),
    .ar_burst_i        (arBurst),
    .ar_rsp_valid_o    (arRspValid),
    .ar_rsp_ready_i    (arRspReady),
    .ar_rsp_allow_o    (arRspAllow),
    .aw_valid_i        (awValid),
    .aw_ready_o        (awReady),
    .aw_addr_i         (awAddr),
    .aw_len_i          (awLen),
    .aw_size_i         (awSize),
    .aw_burst_i        (awBurst),
    .aw_rsp_valid_o    (awRspValid),
    .aw_rsp_ready_i    (awRspReady),
    .aw_rsp_allow_o    (awRspAllow),
    .pmp_addr_o        (pmpAddr),
    .pmp_access_type_o (pmpAccess),
    .pmp_allow_i       (pmpAllow)
  );

  always #5 clk = ~clk;

  // PMP model: a single denied address range.
  always_comb pmpAllow = !((pmpAddr >= denyLo) && (pmpAddr <= denyHi));

  function automatic bit regionAllows(input logic [55:0] a);
    return !((a >= denyLo) && (a <= denyHi));
  endfunction

  function automatic void refBurst(input logic [55:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   output logic [55:0] last, output bit err);
    longint unsigned a, bytes, total, r;
    a     = 64'(addr);
    bytes = 64'd1 << size;
    total = (64'(len) + 64'd1) * bytes;
    case (burst)
      2'b00:   r = (a / bytes) * bytes + bytes - 1;
      2'b01:   r = (a / bytes) * bytes + total - 1;
      2'b10:   r = (a / total) * total + total - 1;
      default: r = a;
    endcase
    err  = (burst == 2'b11) || (r >= (64'd1 << 56));
    last = r[55:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on one channel, optionally holding the verdict for `stall`
  // cycles and raising a competing AW request meanwhile.
  task automatic applyStimulus(input bit isAw, input logic [55:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int stall, input bit pendAw);
    logic [55:0] expLast;
    bit          expErr, expAllow;
    pmp_access_t expType;
    int          n;
    refBurst(addr, len, size, burst, expLast, expErr);
    expAllow = !expErr && regionAllows(addr) && regionAllows(expLast);
    expType  = isAw ? ACCESS_WRITE : ACCESS_READ;
    @(negedge clk);
    if (isAw) begin
      awAddr = addr; awLen = len; awSize = size; awBurst = burst; awValid = 1'b1; awRspReady = 1'b0;
    end else begin
      arAddr = addr; arLen = len; arSize = size; arBurst = burst; arValid = 1'b1; arRspReady = 1'b0;
    end
    #1;
    n = 0;
    while (!(isAw ? awReady : arReady) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    checkOutput("grant", isAw ? awReady : arReady, 1);
    @(negedge clk);
    if (isAw) awValid = 1'b0; else arValid = 1'b0;
    #1;
    checkOutput("ready_drop", arReady | awReady, 0);
    checkOutput("first_addr", pmpAddr, addr);
    checkOutput("first_type", pmpAccess, expType);
    @(negedge clk); #1;
    if (!expErr) checkOutput("last_addr", pmpAddr, expLast);
    checkOutput("last_type", pmpAccess, expType);
    @(negedge clk); #1;
    checkOutput("rsp_valid", isAw ? awRspValid : arRspValid, 1);
    checkOutput("rsp_other", isAw ? arRspValid : awRspValid, 0);
    checkOutput("rsp_allow", isAw ? awRspAllow : arRspAllow, expAllow);
    checkOutput("rsp_type", pmpAccess, ACCESS_NONE);
    for (int i = 0; i < stall; i++) begin
      if (pendAw && i == 0) awValid = 1'b1;
      @(negedge clk); #1;
      checkOutput("stall_valid", isAw ? awRspValid : arRspValid, 1);
      checkOutput("stall_allow", isAw ? awRspAllow : arRspAllow, expAllow);
      if (pendAw) checkOutput("stall_no_grant", awReady, 0);
    end
    if (isAw) awRspReady = 1'b1; else arRspReady = 1'b1;
    @(negedge clk);
    if (isAw) awRspReady = 1'b0; else arRspReady = 1'b0;
    #1;
    checkOutput("rsp_done", isAw ? awRspValid : arRspValid, 0);
    if (pendAw) checkOutput("pend_grant", awReady, 1);
  endtask

  initial begin
    bit          expAw, isAw, err;
    int          n, mode;
    logic [63:0] rnd;
    logic [55:0] addr, last;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;

    rst = 1'b1; priv = PRIV_LVL_M;
    arValid = 0; arAddr = '0; arLen = '0; arSize = '0; arBurst = '0; arRspReady = 0;
    awValid = 0; awAddr = '0; awLen = '0; awSize = '0; awBurst = '0; awRspReady = 0;
    denyLo = '1; denyHi = '0;
    #1;
    checkOutput("reset_ar_rsp_valid", arRspValid, 0);
    checkOutput("reset_aw_rsp_valid", awRspValid, 0);
    checkOutput("reset_ar_allow", arRspAllow, 0);
    checkOutput("reset_pmp_addr", pmpAddr, 0);
    checkOutput("reset_pmp_type", pmpAccess, ACCESS_NONE);
    @(negedge clk); rst = 1'b0;

    $display("[TB] AR INCR, PMP allows both bytes");
    applyStimulus(1'b0, 56'h8000_0000, 8'd3, 3'd3, 2'b01, 0, 1'b0);

    $display("[TB] AW INCR, PMP denies last byte");
    denyLo = 56'h1000_0FF8; denyHi = 56'h1000_0FFF;
    applyStimulus(1'b1, 56'h1000_0FF0, 8'd1, 3'd3, 2'b01, 0, 1'b0);

    $display("[TB] WRAP burst and reserved burst");
    denyLo = '1; denyHi = '0;
    applyStimulus(1'b0, 56'h2000_0034, 8'd3, 3'd2, 2'b10, 0, 1'b0);
    applyStimulus(1'b1, 56'h2000_0034, 8'd3, 3'd2, 2'b11, 0, 1'b0);

    $display("[TB] verdict backpressure with pending AW");
    awAddr = 56'h3000_0000; awLen = 8'd0; awSize = 3'd2; awBurst = 2'b01;
    applyStimulus(1'b0, 56'h6000_0000, 8'd0, 3'd2, 2'b01, 5, 1'b1);
    awRspReady = 1'b1;
    @(negedge clk); awValid = 1'b0; #1;
    checkOutput("pend_first", pmpAddr, 56'h3000_0000);
    checkOutput("pend_type", pmpAccess, ACCESS_WRITE);
    @(negedge clk); @(negedge clk); #1;
    checkOutput("pend_rsp", awRspValid, 1);
    checkOutput("pend_allow", awRspAllow, 1);
    @(negedge clk); awRspReady = 1'b0; #1;
    checkOutput("pend_done", awRspValid, 0);

    $display("[TB] reset during CHK_LAST");
    @(negedge clk);
    arAddr = 56'h7000_0000; arLen = 8'd0; arSize = 3'd3; arBurst = 2'b01; arValid = 1'b1; arRspReady = 1'b1;
    #1; checkOutput("rst_grant", arReady, 1);
    @(negedge clk); arValid = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_pre_type", pmpAccess, ACCESS_READ);
    rst = 1'b1; #1;
    checkOutput("rst_pmp_addr", pmpAddr, 0);
    checkOutput("rst_pmp_type", pmpAccess, ACCESS_NONE);
    checkOutput("rst_ar_rsp", arRspValid, 0);
    checkOutput("rst_ar_allow", arRspAllow, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1; checkOutput("rst_discard", arRspValid, 0);

    $display("[TB] both channels valid from reset");
    rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0;
    arAddr = 56'h4000_0000; arLen = 0; arSize = 3; arBurst = 2'b01; arRspReady = 1'b1;
    awAddr = 56'h5000_0000; awLen = 0; awSize = 3; awBurst = 2'b01; awRspReady = 1'b1;
    arValid = 1'b1; awValid = 1'b1;
    for (int g = 0; g < 8; g++) begin
      expAw = (g % 2) == 1;
      #1; n = 0;
      while (!(arReady || awReady) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      checkOutput("arb_ar", arReady, !expAw);
      checkOutput("arb_aw", awReady, expAw);
      @(negedge clk); #1;
      checkOutput("arb_type", pmpAccess, expAw ? ACCESS_WRITE : ACCESS_READ);
      @(negedge clk); @(negedge clk); #1;
      checkOutput("arb_rsp_ar", arRspValid, !expAw);
      checkOutput("arb_rsp_aw", awRspValid, expAw);
      @(negedge clk);
    end
    arValid = 1'b0; awValid = 1'b0; arRspReady = 1'b0; awRspReady = 1'b0;

    $display("[TB] randomized bursts");
    for (int r = 0; r < 30; r++) begin
      isAw  = 1'($urandom_range(0, 1));
      burst = 2'($urandom_range(0, 3));
      size  = 3'($urandom_range(0, 7));
      len   = (burst == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 255));
      rnd   = {$urandom(), $urandom()};
      addr  = rnd[55:0];
      if ($urandom_range(0, 3) == 0) addr = addr | 56'hFF_FFFF_FFFF_0000;
      refBurst(addr, len, size, burst, last, err);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin denyLo = '1; denyHi = '0; end
        1: begin denyLo = addr; denyHi = addr; end
        2: begin denyLo = last; denyHi = last; end
        default: begin denyLo = addr; denyHi = (last >= addr) ? last : addr; end
      endcase
      applyStimulus(isAw, addr, len, size, burst, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
